// File: rtl/canny_pkg.sv
// -----------------------------------------------------------------------------
// canny_pkg
// Shared types for the edge-detector pipeline window buffers.
//   shift_dir_t : encoding of the shift_direction port (LEFT/UP/DOWN/FLUSH)
//   win_state_t : fill state of a sliding window buffer
//   MAX_WIN     : largest supported window edge length
// -----------------------------------------------------------------------------
package canny_pkg;

  typedef enum logic [1:0] {
    SHIFT_LEFT  = 2'b00,
    SHIFT_UP    = 2'b01,
    SHIFT_DOWN  = 2'b10,
    SHIFT_FLUSH = 2'b11
  } shift_dir_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    FILLING = 2'b01,
    VALID   = 2'b10
  } win_state_t;

  localparam int MAX_WIN = 9;

endpackage

// File: rtl/window_buffer_nxn.sv
// -----------------------------------------------------------------------------
// window_buffer_nxn
// Parametrised NxN sliding-window register buffer with serpentine scan support
// (LEFT column shifts, UP/DOWN row shifts), fill tracking and a sticky
// scan-order error. All outputs come straight from registers.
//
// Ports
//   clk             in   system clock, rising edge
//   rst             in   synchronous reset, active high (overrides shift_enable)
//   shift_enable    in   perform the operation selected by shift_direction
//   shift_direction in   00 LEFT, 01 UP, 10 DOWN, 11 FLUSH
//   buffer_input    in   N*DW   new column (LEFT) or row (UP/DOWN), entry k at [k*DW +: DW]
//   buffer_output   out  N*N*DW window, pixel [r][c] at [(r*N+c)*DW +: DW]
//   center_out      out  DW     pixel [N/2][N/2]
//   window_valid    out  window fully populated since last flush/reset
//   fill_count      out  columns loaded, saturating at N
//   error           out  sticky: UP/DOWN issued before the window was full
//
// FSM
//   state   | meaning
//   EMPTY   | nothing loaded since reset/flush
//   FILLING | 1..N-1 columns loaded
//   VALID   | N columns loaded, window_valid asserted
// -----------------------------------------------------------------------------
module window_buffer_nxn
  import canny_pkg::*;
#(
  parameter int N  = 3,
  parameter int DW = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     shift_enable,
  input  logic [1:0]               shift_direction,
  input  logic [N*DW-1:0]          buffer_input,
  output logic [N*N*DW-1:0]        buffer_output,
  output logic [DW-1:0]            center_out,
  output logic                     window_valid,
  output logic [$clog2(N+1)-1:0]   fill_count,
  output logic                     error
);

  localparam int              CW       = $clog2(N+1);
  localparam logic [CW-1:0]   FILL_MAX = CW'(N);

  if ((N % 2) == 0 || N < 3 || N > MAX_WIN) begin : g_bad_n
    $error("window_buffer_nxn: N=%0d must be odd and within 3..%0d", N, MAX_WIN);
  end

  shift_dir_t dir;
  assign dir = shift_dir_t'(shift_direction);

  win_state_t        state_q, state_d;
  logic [CW-1:0]     fill_q,  fill_d;
  logic              err_q,   err_d;
  logic [DW-1:0]     pix_q [0:N-1][0:N-1];
  logic [DW-1:0]     pix_d [0:N-1][0:N-1];

  // Fill / error state machine.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    err_d   = err_q;
    if (shift_enable) begin
      case (dir)
        SHIFT_LEFT: begin
          case (state_q)
            EMPTY: begin
              fill_d  = CW'(1);
              state_d = FILLING;
            end
            FILLING: begin
              fill_d = fill_q + CW'(1);
              if (fill_q + CW'(1) == FILL_MAX) state_d = VALID;
            end
            VALID:   state_d = VALID;
            default: state_d = EMPTY;
          endcase
        end
        SHIFT_UP, SHIFT_DOWN: begin
          // Row shifts before the window is full break the serpentine order;
          // the data still moves, and the flag holds until a flush.
          if (state_q != VALID) err_d = 1'b1;
        end
        SHIFT_FLUSH: begin
          state_d = EMPTY;
          fill_d  = '0;
          err_d   = 1'b0;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Pixel shift muxes.
  always_comb begin
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        pix_d[r][c] = pix_q[r][c];
    if (shift_enable) begin
      case (dir)
        SHIFT_LEFT: begin
          for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N-1; c++) pix_d[r][c] = pix_q[r][c+1];
            pix_d[r][N-1] = buffer_input[r*DW +: DW];
          end
        end
        SHIFT_UP: begin
          for (int c = 0; c < N; c++) begin
            for (int r = 0; r < N-1; r++) pix_d[r][c] = pix_q[r+1][c];
            pix_d[N-1][c] = buffer_input[c*DW +: DW];
          end
        end
        SHIFT_DOWN: begin
          for (int c = 0; c < N; c++) begin
            for (int r = 1; r < N; r++) pix_d[r][c] = pix_q[r-1][c];
            pix_d[0][c] = buffer_input[c*DW +: DW];
          end
        end
        SHIFT_FLUSH: begin
          for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
              pix_d[r][c] = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      fill_q  <= '0;
      err_q   <= 1'b0;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          pix_q[r][c] <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          pix_q[r][c] <= pix_d[r][c];
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      assign buffer_output[(r*N+c)*DW +: DW] = pix_q[r][c];
    end
  end

  assign center_out   = pix_q[N/2][N/2];
  assign window_valid = (state_q == VALID);
  assign fill_count   = fill_q;
  assign error        = err_q;

endmodule

// File: tb/tb_window_buffer_nxn.sv
// -----------------------------------------------------------------------------
// tb_window_buffer_nxn
// Runs three window_buffer_nxn configurations side by side (N=3/DW=8,
// N=5/DW=12, N=9/DW=12). Each driver pushes the expected post-edge state of
// a reference model into a queue; a per-configuration monitor pops one entry
// after every clock edge and compares all outputs against it.
// -----------------------------------------------------------------------------
module tb_window_buffer_nxn;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int N  = (g == 0) ? 3 : ((g == 1) ? 5 : 9);
    localparam int DW = (g == 0) ? 8 : 12;
    localparam int CW = $clog2(N+1);
    localparam int WW = N*N*DW;
    localparam int EW = WW + DW + 1 + CW + 1;

    logic              rst;
    logic              shift_enable;
    logic [1:0]        shift_direction;
    logic [N*DW-1:0]   buffer_input;
    logic [WW-1:0]     buffer_output;
    logic [DW-1:0]     center_out;
    logic              window_valid;
    logic [CW-1:0]     fill_count;
    logic              error;

    bit done = 1'b0;
    logic [EW-1:0] exp_q [$];

    // Reference model: window contents, number of columns loaded since the
    // last clear (saturating at N), and the sticky order error.
    int unsigned m_win [N][N];
    int          m_lefts = 0;
    bit          m_err   = 1'b0;

    window_buffer_nxn #(.N(N), .DW(DW)) u_dut (
      .clk             (clk),
      .rst             (rst),
      .shift_enable    (shift_enable),
      .shift_direction (shift_direction),
      .buffer_input    (buffer_input),
      .buffer_output   (buffer_output),
      .center_out      (center_out),
      .window_valid    (window_valid),
      .fill_count      (fill_count),
      .error           (error)
    );

    function automatic logic [EW-1:0] m_pack();
      logic [EW-1:0] e;
      logic [WW-1:0] w;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          w[(r*N+c)*DW +: DW] = DW'(m_win[r][c]);
      e = {w, DW'(m_win[N/2][N/2]), (m_lefts >= N), CW'(m_lefts), m_err};
      return e;
    endfunction

    task automatic m_step(input bit rs, input bit en, input logic [1:0] d,
                          input logic [N*DW-1:0] din);
      int unsigned t [N][N];
      t = m_win;
      if (rs || (en && d == 2'd3)) begin
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++)
            t[r][c] = 0;
        m_lefts = 0;
        m_err   = 1'b0;
      end else if (en) begin
        for (int r = 0; r < N; r++) begin
          for (int c = 0; c < N; c++) begin
            case (d)
              2'd0: t[r][c] = (c == N-1) ? int'(din[r*DW +: DW]) : m_win[r][c+1];
              2'd1: t[r][c] = (r == N-1) ? int'(din[c*DW +: DW]) : m_win[r+1][c];
              default: t[r][c] = (r == 0) ? int'(din[c*DW +: DW]) : m_win[r-1][c];
            endcase
          end
        end
        if (d == 2'd0) begin
          if (m_lefts < N) m_lefts++;
        end else if (m_lefts < N) begin
          m_err = 1'b1;
        end
      end
      m_win = t;
    endtask

    task automatic drive(input bit rs, input bit en, input logic [1:0] d,
                         input logic [N*DW-1:0] din);
      @(negedge clk);
      rst             = rs;
      shift_enable    = en;
      shift_direction = d;
      buffer_input    = din;
      m_step(rs, en, d, din);
      exp_q.push_back(m_pack());
    endtask

    function automatic logic [N*DW-1:0] rand_line();
      logic [N*DW-1:0] v;
      for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'($urandom);
      return v;
    endfunction

    function automatic logic [N*DW-1:0] seq_line(input int base);
      logic [N*DW-1:0] v;
      for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(base + k);
      return v;
    endfunction

    // Monitor
    initial begin
      logic [EW-1:0] e;
      forever begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_tests++;
          if (buffer_output !== e[EW-1 -: WW]) begin
            n_fail++;
            $display("FAIL N=%0d window: got %h expected %h", N, buffer_output, e[EW-1 -: WW]);
          end
          n_tests++;
          if (center_out !== e[CW+2 +: DW]) begin
            n_fail++;
            $display("FAIL N=%0d center_out: got %h expected %h", N, center_out, e[CW+2 +: DW]);
          end
          n_tests++;
          if (window_valid !== e[CW+1]) begin
            n_fail++;
            $display("FAIL N=%0d window_valid: got %b expected %b", N, window_valid, e[CW+1]);
          end
          n_tests++;
          if (fill_count !== e[CW:1]) begin
            n_fail++;
            $display("FAIL N=%0d fill_count: got %0d expected %0d", N, fill_count, e[CW:1]);
          end
          n_tests++;
          if (error !== e[0]) begin
            n_fail++;
            $display("FAIL N=%0d error: got %b expected %b", N, error, e[0]);
          end
        end
      end
    end

    // Stimulus
    initial begin
      rst = 1'b1; shift_enable = 1'b0; shift_direction = 2'd0; buffer_input = '0;
      drive(1, 0, 2'd0, '0);
      drive(1, 0, 2'd0, '0);
      // reset in the middle of a fill, with shift_enable still high
      drive(0, 1, 2'd0, rand_line());
      drive(0, 1, 2'd0, rand_line());
      drive(1, 1, 2'd0, rand_line());
      drive(0, 0, 2'd0, rand_line());
      // directed fill, then one UP and one DOWN
      for (int j = 0; j < N; j++) drive(0, 1, 2'd0, seq_line(j*N + 1));
      drive(0, 1, 2'd1, seq_line(N*N + 1));
      drive(0, 1, 2'd2, seq_line(N*N + 11));
      // hold
      for (int i = 0; i < 5; i++) drive(0, 0, 2'($urandom_range(0, 3)), rand_line());
      // random legal serpentine traffic while valid
      for (int i = 0; i < 40; i++)
        drive(0, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 2)), rand_line());
      for (int i = 0; i < 5; i++) drive(0, 0, 2'($urandom_range(0, 3)), rand_line());
      // scan-order error, persistence, flush
      drive(1, 0, 2'd0, '0);
      drive(0, 1, 2'd0, rand_line());
      drive(0, 1, 2'd1, rand_line());
      for (int i = 0; i < 3; i++) drive(0, 0, 2'($urandom_range(0, 3)), rand_line());
      drive(0, 1, 2'd3, rand_line());
      drive(0, 1, 2'd2, rand_line());
      drive(0, 1, 2'd0, rand_line());
      drive(0, 1, 2'd3, rand_line());
      // fully random mix, mostly LEFT so the window regularly becomes valid
      for (int i = 0; i < 200; i++) begin
        int sel;
        logic [1:0] d;
        sel = $urandom_range(0, 19);
        d = (sel < 12) ? 2'd0 : (sel < 15) ? 2'd1 : (sel < 18) ? 2'd2 : 2'd3;
        drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0), d, rand_line());
      end
      drive(0, 0, 2'd0, '0);
      repeat (3) @(posedge clk);
      #2;
      n_tests++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL N=%0d scoreboard drain: got %0d entries left expected 0", N, exp_q.size());
      end
      done = 1'b1;
    end
  end

  initial begin
    int cyc;
    cyc = 0;
    while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    if (cyc >= 20000) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: got %0d cycles without completion, required fewer than 20000", cyc);
    end
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
